pbit_sweep_scheduler: RTL and testbench
=======================================

# pbit_sweep_scheduler

Sequencing controller for the time-multiplexed p-bit datapath. It walks row indices 0..NUM_PBITS-1 and handshakes with the weight/bias loader and the shared p-bit evaluator for each row. It counts completed sweeps, flags stalled handshakes with a watchdog, and optionally drives an annealed interconnection strength (beta, replacing the fixed I_0) to the datapath.

## Interface
Parameters:
- NUM_PBITS, 16: number of p-bits (rows) per sweep, ≥2
- SWEEP_W, 16: width of sweep counter and num_sweeps
- BETA_W, 8: beta width, signed Q4.3 (8 = 1.0)
- BETA_INIT, 8: beta after reset/start
- BETA_STEP, 1: beta increment per anneal step
- BETA_MAX, 64: beta saturation value
- ANNEAL_PERIOD, 4: sweeps per anneal step, ≥1
- TIMEOUT_CYCLES, 255: watchdog limit per wait state

Ports (clock and reset first):
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; high starts/continues sweeping
- num_sweeps  in  SWEEP_W  sweeps to perform; 0 = free-running; sampled on start
- start_load  out  1  one-cycle pulse: loader begins row current_row
- current_row  out  $clog2(NUM_PBITS)  row being processed
- load_done  in  1  loader finished row (pulse)
- eval_start  out  1  one-cycle pulse: evaluate p-bit current_row
- eval_done  in  1  p-bit state written back (pulse)
- update_cycle_done  out  1  one-cycle pulse at end of each full sweep
- sweep_count  out  SWEEP_W  completed sweeps since start
- beta  out  signed BETA_W  interconnection strength for datapath
- busy  out  1  FSM not in IDLE/DONE/ERROR
- done  out  1  num_sweeps reached (level)
- error  out  1  watchdog expired (sticky until run low)

## Operation
- States: IDLE, LOAD, WAIT_LOAD, EVAL, WAIT_EVAL, NEXT, DONE, ERROR.
- IDLE: run high → latch num_sweeps, clear sweep_count, current_row=0, beta=BETA_INIT → LOAD.
- LOAD: start_load=1 one cycle → WAIT_LOAD.
- WAIT_LOAD: load_done → EVAL; watchdog reaches TIMEOUT_CYCLES → ERROR.
- EVAL: eval_start=1 one cycle → WAIT_EVAL.
- WAIT_EVAL: eval_done → NEXT; watchdog expiry → ERROR.
- NEXT: row < NUM_PBITS-1 → row+1, LOAD. Last row → row=0, update_cycle_done pulse, sweep_count+1 (wraps at 2^SWEEP_W); if num_sweeps≠0 and new count == num_sweeps → DONE, else LOAD.
- run low: the in-flight row completes through NEXT, then IDLE. No sweep pulse unless that row was the last. A partial sweep is abandoned; restart begins at row 0.
- DONE: done=1; run low → IDLE.
- ERROR: error=1, busy=0; run low → IDLE, clears error.
- load_done/eval_done are ignored outside their wait states. A spurious pulse has no effect.
- Watchdog counter clears on entry to each wait state and saturates.

## Timing
- All outputs registered. Reset values: all 1-bit outputs 0, current_row=0, sweep_count=0, beta=BETA_INIT.
- run sampled high in IDLE at cycle N → start_load high at cycle N+1.
- load_done sampled at cycle M → eval_start at M+1. eval_done at K → NEXT at K+1 → start_load (next row) at K+2.
- Minimum per-row period with zero-latency responders: 5 cycles. Per sweep: 5·NUM_PBITS cycles.
- update_cycle_done, sweep_count increment and beta update land in the same cycle.
- Reset mid-operation: immediate return to IDLE; no pulse is completed.

## Configuration
- PBIT_ANNEAL_EN defined: every ANNEAL_PERIOD completed sweeps, beta += BETA_STEP, saturating at BETA_MAX. Beta resets to BETA_INIT on each start.
- Undefined: beta is the constant BETA_INIT; no anneal logic is synthesized.

## Structure
- Shared package pbit_sched_pkg holds state_t, the Q4.3 beta format constant (BETA_FRAC=3), and BETA_W.
- Sub-module beta_anneal_ramp holds the period counter and saturating beta register, instantiated only under PBIT_ANNEAL_EN.

## Test plan
- NUM_PBITS=4, num_sweeps=2, responders reply 1 cycle after request → 8 start_load/eval_start pairs, rows 0,1,2,3,0,1,2,3; update_cycle_done at the ends of rows 3 and 7; done=1; total 40 cycles.
- Loader never returns load_done, TIMEOUT_CYCLES=10 → error=1 after 10 cycles in WAIT_LOAD; run low → IDLE, error=0.
- run dropped during row 2 of sweep 0 → row 2 completes, no update_cycle_done, IDLE, sweep_count=0; rerun starts at row 0.
- PBIT_ANNEAL_EN, ANNEAL_PERIOD=1, BETA_INIT=62, BETA_STEP=1, BETA_MAX=64 → beta sequence 62, 63, 64, 64.
- num_sweeps=0 for 3 sweeps with a spurious eval_done during WAIT_LOAD → free-runs; the pulse is ignored; sweep_count=3; done stays 0.
- reset_n asserted mid-WAIT_EVAL → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pbit_sched_pkg.sv
// pbit_sched_pkg
//   Shared definitions for the p-bit sweep scheduler slice.
//   - BETA_W / BETA_FRAC : default width and fraction bits of the signed
//                          Q4.3 interconnection strength (1 << BETA_FRAC = 1.0)
//   - state_t / ST_*     : sequencer state encoding
//   - is_active()        : true for states that count as "busy"
package pbit_sched_pkg;

  localparam int BETA_W    = 8;
  localparam int BETA_FRAC = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_WAIT_LOAD = 3'd2;
  localparam state_t ST_EVAL      = 3'd3;
  localparam state_t ST_WAIT_EVAL = 3'd4;
  localparam state_t ST_NEXT      = 3'd5;
  localparam state_t ST_DONE      = 3'd6;
  localparam state_t ST_ERROR     = 3'd7;

  // Busy covers every state that is part of walking a row.
  function automatic logic is_active(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/beta_anneal_ramp.sv
// beta_anneal_ramp
//   Annealing schedule for the interconnection strength beta. Every
//   ANNEAL_PERIOD sweep ticks, beta increases by BETA_STEP and saturates at
//   BETA_MAX. A restart pulse returns beta to BETA_INIT and clears the period.
//   Only instantiated when PBIT_ANNEAL_EN is defined.
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   restart    in   one-cycle pulse: new run begins
//   sweep_tick in   one-cycle pulse: a full sweep completed
//   beta       out  signed BETA_W, registered
module beta_anneal_ramp #(
  parameter int BETA_W        = 8,
  parameter int BETA_INIT     = 8,
  parameter int BETA_STEP     = 1,
  parameter int BETA_MAX      = 64,
  parameter int ANNEAL_PERIOD = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     restart,
  input  logic                     sweep_tick,
  output logic signed [BETA_W-1:0] beta
);

  localparam int PER_W = (ANNEAL_PERIOD > 1) ? $clog2(ANNEAL_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(ANNEAL_PERIOD - 1);

  logic [PER_W-1:0]       period_reg;
  // One guard bit so beta + step cannot wrap before the saturation compare.
  logic signed [BETA_W:0] beta_sum;

  always_comb begin
    beta_sum = $signed({beta[BETA_W-1], beta}) + $signed((BETA_W+1)'(BETA_STEP));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_reg <= '0;
      beta       <= BETA_W'(BETA_INIT);
    end else if (restart) begin
      period_reg <= '0;
      beta       <= BETA_W'(BETA_INIT);
    end else if (sweep_tick) begin
      if (period_reg == PER_LAST) begin
        period_reg <= '0;
        if (beta_sum >= $signed((BETA_W+1)'(BETA_MAX))) begin
          beta <= BETA_W'(BETA_MAX);
        end else begin
          beta <= beta_sum[BETA_W-1:0];
        end
      end else begin
        period_reg <= period_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// pbit_sweep_scheduler
//   Sequencer for the time-multiplexed p-bit datapath. Walks rows
//   0..NUM_PBITS-1, handshaking with the weight/bias loader and the shared
//   p-bit evaluator per row, counts completed sweeps, traps stalled
//   handshakes with a watchdog and drives beta to the datapath.
//   Build option: define PBIT_ANNEAL_EN to ramp beta every ANNEAL_PERIOD
//   sweeps (beta_anneal_ramp); otherwise beta is the constant BETA_INIT.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   run                 level: start / keep sweeping
//   num_sweeps          sweeps to run (0 = free-running), sampled at start
//   start_load          pulse: loader begins row current_row
//   current_row         row being processed
//   load_done           loader finished (pulse, honoured in WAIT_LOAD only)
//   eval_start          pulse: evaluate p-bit current_row
//   eval_done           evaluation written back (pulse, WAIT_EVAL only)
//   update_cycle_done   pulse: a full sweep completed
//   sweep_count         completed sweeps since start (wraps)
//   beta                signed Q4.3 interconnection strength
//   busy / done / error status levels
module pbit_sweep_scheduler #(
  parameter int NUM_PBITS      = 16,
  parameter int SWEEP_W        = 16,
  parameter int BETA_W         = pbit_sched_pkg::BETA_W,
  parameter int BETA_INIT      = 1 << pbit_sched_pkg::BETA_FRAC,
  parameter int BETA_STEP      = 1,
  parameter int BETA_MAX       = 64,
  parameter int ANNEAL_PERIOD  = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ROW_W         = $clog2(NUM_PBITS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic [SWEEP_W-1:0]       num_sweeps,
  output logic                     start_load,
  output logic [ROW_W-1:0]         current_row,
  input  logic                     load_done,
  output logic                     eval_start,
  input  logic                     eval_done,
  output logic                     update_cycle_done,
  output logic [SWEEP_W-1:0]       sweep_count,
  output logic signed [BETA_W-1:0] beta,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  import pbit_sched_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_PBITS - 1);

  // Reject configurations the sequencer cannot honour at elaboration time.
  if ((NUM_PBITS < 2) || (ANNEAL_PERIOD < 1) || (TIMEOUT_CYCLES < 1) ||
      (BETA_STEP < 0) || (BETA_MAX < BETA_INIT)) begin : g_cfg_check
    $error("pbit_sweep_scheduler: illegal parameter combination");
  end

  state_t              state_reg;
  state_t              state_next;
  logic [SWEEP_W-1:0]  num_sweeps_reg;
  logic [WD_W-1:0]     wd_reg;

  logic last_row;
  logic wd_expired;
  logic start;
  logic sweep_tick;
  logic target_hit;
  logic wait_entry;

  always_comb begin
    last_row   = (current_row == LAST_ROW);
    // The wait state being left is the TIMEOUT_CYCLES-th cycle spent there.
    wd_expired = (wd_reg >= WD_LIMIT);
    start      = (state_reg == ST_IDLE) && run;
    // Sweep completion is booked on the WAIT_EVAL->NEXT edge so the pulse,
    // the count and the beta update all appear together in the NEXT cycle.
    sweep_tick = (state_reg == ST_WAIT_EVAL) && eval_done && last_row;
    // sweep_count already holds the new count while in NEXT.
    target_hit = last_row && (num_sweeps_reg != '0) && (sweep_count == num_sweeps_reg);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (run) state_next = ST_LOAD;
      ST_LOAD:      state_next = ST_WAIT_LOAD;
      ST_WAIT_LOAD: begin
        if (load_done)       state_next = ST_EVAL;
        else if (wd_expired) state_next = ST_ERROR;
      end
      ST_EVAL:      state_next = ST_WAIT_EVAL;
      ST_WAIT_EVAL: begin
        if (eval_done)       state_next = ST_NEXT;
        else if (wd_expired) state_next = ST_ERROR;
      end
      ST_NEXT: begin
        // Reaching the target wins over run low so done is still reported.
        if (target_hit)      state_next = ST_DONE;
        else if (!run)       state_next = ST_IDLE;
        else                 state_next = ST_LOAD;
      end
      ST_DONE:      if (!run) state_next = ST_IDLE;
      ST_ERROR:     if (!run) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_entry = ((state_next == ST_WAIT_LOAD) || (state_next == ST_WAIT_EVAL)) &&
                 (state_next != state_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      num_sweeps_reg    <= '0;
      wd_reg            <= '0;
      current_row       <= '0;
      sweep_count       <= '0;
      start_load        <= 1'b0;
      eval_start        <= 1'b0;
      update_cycle_done <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
    end else begin
      state_reg         <= state_next;

      // Status and strobes are decoded from the next state so they are
      // registered yet aligned with the state they describe.
      start_load        <= (state_next == ST_LOAD);
      eval_start        <= (state_next == ST_EVAL);
      busy              <= is_active(state_next);
      done              <= (state_next == ST_DONE);
      error             <= (state_next == ST_ERROR);
      update_cycle_done <= sweep_tick;

      if (start) begin
        num_sweeps_reg <= num_sweeps;
        sweep_count    <= '0;
        current_row    <= '0;
      end else if (sweep_tick) begin
        sweep_count    <= sweep_count + 1'b1;
      end

      // A partial sweep abandoned by run low restarts from row 0.
      if (state_reg == ST_NEXT) begin
        if (last_row || (state_next != ST_LOAD)) begin
          current_row <= '0;
        end else begin
          current_row <= current_row + 1'b1;
        end
      end

      if (wait_entry) begin
        wd_reg <= '0;
      end else if (wd_reg != {WD_W{1'b1}}) begin
        wd_reg <= wd_reg + 1'b1;
      end
    end
  end

`ifdef PBIT_ANNEAL_EN
  beta_anneal_ramp #(
    .BETA_W        (BETA_W),
    .BETA_INIT     (BETA_INIT),
    .BETA_STEP     (BETA_STEP),
    .BETA_MAX      (BETA_MAX),
    .ANNEAL_PERIOD (ANNEAL_PERIOD)
  ) u_beta_ramp (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart    (start),
    .sweep_tick (sweep_tick),
    .beta       (beta)
  );
`else
  // Fixed interconnection strength: no anneal state at all.
  assign beta = BETA_W'(BETA_INIT);
`endif

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// tb_pbit_sweep_scheduler
//   Directed bench: a table of sweep scenarios driven through a responder
//   model, plus hand-written sequences for watchdog expiry and asynchronous
//   reset in the middle of WAIT_EVAL. Works with or without PBIT_ANNEAL_EN.
`timescale 1ns/1ps
module tb_pbit_sweep_scheduler;

  localparam int NP    = 4;
  localparam int SW    = 16;
  localparam int BW    = 8;
  localparam int BINIT = 62;
  localparam int BSTEP = 1;
  localparam int BMAX  = 64;
  localparam int APER  = 1;
  localparam int TMO   = 10;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 run = 1'b0;
  logic [SW-1:0]        num_sweeps = '0;
  logic                 load_done = 1'b0;
  logic                 eval_done = 1'b0;
  logic                 start_load;
  logic [1:0]           current_row;
  logic                 eval_start;
  logic                 update_cycle_done;
  logic [SW-1:0]        sweep_count;
  logic signed [BW-1:0] beta;
  logic                 busy;
  logic                 done;
  logic                 error;

  pbit_sweep_scheduler #(
    .NUM_PBITS      (NP),
    .SWEEP_W        (SW),
    .BETA_W         (BW),
    .BETA_INIT      (BINIT),
    .BETA_STEP      (BSTEP),
    .BETA_MAX       (BMAX),
    .ANNEAL_PERIOD  (APER),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .run               (run),
    .num_sweeps        (num_sweeps),
    .start_load        (start_load),
    .current_row       (current_row),
    .load_done         (load_done),
    .eval_start        (eval_start),
    .eval_done         (eval_done),
    .update_cycle_done (update_cycle_done),
    .sweep_count       (sweep_count),
    .beta              (beta),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  always #5 clk = ~clk;

  // Responder: replies lat cycles after each request, optionally never
  // (resp_en=0), optionally with a stray eval_done alongside load_done.
  int lat     = 1;
  bit resp_en = 1'b1;
  bit spur    = 1'b0;
  int ld_cnt  = 0;
  int ev_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      load_done = 1'b0;
      eval_done = 1'b0;
      if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0 && resp_en) load_done = 1'b1;
      end
      if (ev_cnt > 0) begin
        ev_cnt--;
        if (ev_cnt == 0 && resp_en) eval_done = 1'b1;
      end
      if (spur && load_done) eval_done = 1'b1;
      if (start_load) ld_cnt = lat;
      if (eval_start) ev_cnt = lat;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_beta(input int sweeps);
    int b;
`ifdef PBIT_ANNEAL_EN
    b = BINIT + (sweeps / APER) * BSTEP;
    if (b > BMAX) b = BMAX;
`else
    b = BINIT;
`endif
    return b;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " start_load"}, start_load, 0);
    check({tag, " eval_start"}, eval_start, 0);
    check({tag, " current_row"}, current_row, 0);
    check({tag, " update_cycle_done"}, update_cycle_done, 0);
    check({tag, " sweep_count"}, sweep_count, 0);
    check({tag, " beta"}, beta, BINIT);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
  endtask

  typedef struct {
    int ns;          // num_sweeps
    int lat;         // responder latency in cycles
    bit spur;        // stray eval_done during WAIT_LOAD
    int drop_after;  // drop run on this start_load (1-based), 0 = never
    int exp_pairs;
    int exp_sweeps;
    int exp_busy;    // cycles with busy high
    int exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int pairs = 0, evals = 0, pulses = 0, busy_cyc = 0, guard = 0;
    bit seen_busy = 1'b0, finished = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    num_sweeps = SW'(v.ns);
    lat        = v.lat;
    spur       = v.spur;
    resp_en    = 1'b1;
    run        = 1'b1;
    @(negedge clk);
    check({tag, " start latency"}, start_load, 1);
    check({tag, " beta at start"}, beta, exp_beta(0));
    while (!finished && guard < 3000) begin
      if (busy) begin
        busy_cyc++;
        seen_busy = 1'b1;
      end
      if (start_load) begin
        check({tag, " load row"}, current_row, pairs % NP);
        pairs++;
        if (v.drop_after != 0 && pairs == v.drop_after) run = 1'b0;
      end
      if (eval_start) begin
        check({tag, " eval row"}, current_row, evals % NP);
        evals++;
      end
      if (update_cycle_done) begin
        pulses++;
        check({tag, " pulse at sweep end"}, pairs % NP, 0);
        check({tag, " sweep_count at pulse"}, sweep_count, pulses);
        check({tag, " beta at pulse"}, beta, exp_beta(pulses));
      end
      if (seen_busy && !busy) begin
        finished = 1'b1;
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    if (!finished) check({tag, " completion within budget"}, 0, 1);
    check({tag, " start_load count"}, pairs, v.exp_pairs);
    check({tag, " eval_start count"}, evals, v.exp_pairs);
    check({tag, " sweep pulses"}, pulses, v.exp_sweeps);
    check({tag, " sweep_count"}, sweep_count, v.exp_sweeps);
    check({tag, " busy cycles"}, busy_cyc, v.exp_busy);
    check({tag, " done"}, done, v.exp_done);
    check({tag, " error"}, error, 0);
    $display("vec %0d: ns=%0d lat=%0d pairs=%0d sweeps=%0d busy=%0d done=%0d",
             idx, v.ns, v.lat, pairs, pulses, busy_cyc, done);
    run = 1'b0;
    spur = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle done"}, done, 0);
  endtask

  initial begin
    vec_t vecs[6];
    int guard;
    vecs[0] = '{ns:2, lat:1, spur:1'b0, drop_after:0,  exp_pairs:8,  exp_sweeps:2, exp_busy:40, exp_done:1};
    vecs[1] = '{ns:1, lat:3, spur:1'b0, drop_after:0,  exp_pairs:4,  exp_sweeps:1, exp_busy:36, exp_done:1};
    vecs[2] = '{ns:0, lat:1, spur:1'b1, drop_after:12, exp_pairs:12, exp_sweeps:3, exp_busy:60, exp_done:0};
    vecs[3] = '{ns:0, lat:1, spur:1'b0, drop_after:3,  exp_pairs:3,  exp_sweeps:0, exp_busy:15, exp_done:0};
    vecs[4] = '{ns:1, lat:2, spur:1'b0, drop_after:0,  exp_pairs:4,  exp_sweeps:1, exp_busy:28, exp_done:1};
    vecs[5] = '{ns:3, lat:1, spur:1'b0, drop_after:0,  exp_pairs:12, exp_sweeps:3, exp_busy:60, exp_done:1};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset busy", busy, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Watchdog: loader never answers.
    @(negedge clk);
    resp_en    = 1'b0;
    lat        = 1;
    num_sweeps = '0;
    run        = 1'b1;
    @(negedge clk);
    check("wd start_load", start_load, 1);
    repeat (TMO) @(negedge clk);
    check("wd error before limit", error, 0);
    check("wd busy before limit", busy, 1);
    @(negedge clk);
    check("wd error at limit", error, 1);
    check("wd busy in error", busy, 0);
    @(negedge clk);
    check("wd error sticky", error, 1);
    run = 1'b0;
    @(negedge clk);
    check("wd error cleared", error, 0);
    check("wd idle busy", busy, 0);
    $display("watchdog: expired after %0d cycles, cleared by run low", TMO);
    resp_en = 1'b1;

    // Asynchronous reset during WAIT_EVAL of row 2, second sweep.
    @(negedge clk);
    lat        = 1;
    num_sweeps = '0;
    run        = 1'b1;
    guard      = 0;
    while (!(eval_start && current_row == 2'd2 && sweep_count == 1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ar reached row 2 of sweep 1", guard < 200 ? 1 : 0, 1);
    @(negedge clk);
    check("ar busy in WAIT_EVAL", busy, 1);
    check("ar beta before reset", beta, exp_beta(1));
    #2 reset_n = 1'b0;
    #1 check_reset_values("async reset");
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ar idle after release", busy, 0);
    $display("async reset: outputs returned to reset values mid-WAIT_EVAL");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
